// File: rtl/forwarding_scoreboard.sv
// Pipeline forwarding scoreboard: tracks in-flight writers, selects forwarding sources, flags load-use.
// Optional registered stall counter output stall_cnt is enabled by defining FWD_STALL_COUNT_EN.
module forwarding_scoreboard #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [NUM_SRC*REG_AW-1:0] issue_src,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_regwrite,
    input  logic                      issue_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*3-1:0]      fwd_sel
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    if (DEPTH < 2 || DEPTH > 7) begin : gBadDepth
        $error("forwarding_scoreboard: DEPTH must be in 2..7");
    end

    logic [DEPTH-1:0]       validQ;
    logic [DEPTH-1:0]       regwriteQ;
    logic [DEPTH-1:0]       isLoadQ;
    logic [REG_AW-1:0]      rdQ [DEPTH];

    logic [NUM_SRC-1:0]     opHit;
    logic [2:0]             opStage [NUM_SRC];
    logic                   loadUse;
    logic                   issueOk;
    logic [NUM_SRC*3-1:0]   fwdSelD;
    logic [NUM_SRC*3-1:0]   fwdSelQ;

    // Descending scan so the youngest matching stage is the one left standing.
    always_comb begin : matchLogic
        loadUse = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            opHit[i]   = 1'b0;
            opStage[i] = 3'd0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (validQ[k] && regwriteQ[k] && (rdQ[k] != '0) &&
                    (rdQ[k] == issue_src[i*REG_AW +: REG_AW])) begin
                    opHit[i]   = 1'b1;
                    opStage[i] = 3'(k);
                end
            end
            if (opHit[i] && (opStage[i] == 3'd0) && isLoadQ[0]) begin
                loadUse = 1'b1;
            end
        end
    end

    assign stall   = ~rst & issue_valid & ~flush & loadUse;
    assign issueOk = issue_valid & ~flush & ~stall;

    // Select k+1 names the producer's stage at issue time; the oldest stage writes the
    // register file this cycle, so its value is read normally.
    always_comb begin : selLogic
        fwdSelD = '0;
        if (issueOk) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (opHit[i] && (opStage[i] != 3'(DEPTH - 1))) begin
                    fwdSelD[i*3 +: 3] = opStage[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : entryRegs
        if (rst) begin
            validQ    <= '0;
            regwriteQ <= '0;
            isLoadQ   <= '0;
            fwdSelQ   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rdQ[k] <= '0;
            end
        end else begin
            validQ    <= {validQ[DEPTH-2:0], issueOk};
            regwriteQ <= {regwriteQ[DEPTH-2:0], issue_regwrite};
            isLoadQ   <= {isLoadQ[DEPTH-2:0], issue_is_load};
            fwdSelQ   <= fwdSelD;
            rdQ[0]    <= issue_rd;
            for (int k = 1; k < DEPTH; k++) begin
                rdQ[k] <= rdQ[k-1];
            end
        end
    end

    assign fwd_sel = fwdSelQ;

`ifdef FWD_STALL_COUNT_EN
    logic [15:0] stallCntQ;

    always_ff @(posedge clk or posedge rst) begin : stallCounter
        if (rst) begin
            stallCntQ <= '0;
        end else if (stall && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

endmodule
